// File: rtl/tetromino_bag_if.sv
// tetromino_bag_if: piece handshake plus random-word feed between the bag and its consumer.
interface tetromino_bag_if #(parameter int RAND_W = 15);
  logic [RAND_W-1:0] rand_in;
  logic              piece_ready;
  logic              piece_valid;
  logic [2:0]        piece_id;
  logic [2:0]        bag_remaining;
  modport master (input rand_in, piece_ready, output piece_valid, piece_id, bag_remaining);
  modport slave (output rand_in, piece_ready, input piece_valid, piece_id, bag_remaining);
endinterface

// File: rtl/tetromino_bag.sv
// tetromino_bag: 7-bag tetromino randomizer with bounded retries and lowest-free fallback.
module tetromino_bag #(
  parameter int RAND_W    = 15,
  parameter int RETRY_MAX = 15
) (
  input logic              clk,
  input logic              nreset,
  tetromino_bag_if.master  bus
);
  localparam int RW = $clog2(RETRY_MAX + 1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t        state_q;
  logic [6:0]    mask_q, mask_d, grown;
  logic [2:0]    piece_q, cand, low, pick;
  logic [RW-1:0] retry_q;
  logic [7:0]    used;
  logic          accept, load, unused_hi;
  assign unused_hi = ^bus.rand_in[RAND_W-1:3];
  assign cand   = bus.rand_in[2:0];
  assign used   = {1'b1, mask_q};
  assign accept = !used[cand];
  assign load   = accept || retry_q == RW'(RETRY_MAX);
  // FILL never sees a full mask, so some bit is always free here
  always_comb begin
    low = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (!mask_q[i]) low = 3'(i);
  end
  assign pick   = accept ? cand : low;
  assign grown  = mask_q | (7'd1 << pick);
  assign mask_d = &grown ? 7'h00 : grown;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= FILL;
      mask_q  <= '0;
      piece_q <= '0;
      retry_q <= '0;
    end else if (state_q == FILL) begin
      if (load) begin
        piece_q <= pick;
        mask_q  <= mask_d;
        state_q <= HOLD;
      end else
        retry_q <= retry_q + RW'(1);
    end else if (bus.piece_ready) begin
      state_q <= FILL;
      retry_q <= '0;
    end
  assign bus.piece_valid   = state_q == HOLD;
  assign bus.piece_id      = piece_q;
  assign bus.bag_remaining = 3'(7 - $countones(mask_q));
endmodule

// File: tb/tb_tetromino_bag.sv
// tb_tetromino_bag: directed vector table plus multi-cycle corner sequences for tetromino_bag.
module tb_tetromino_bag;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  tetromino_bag_if #(.RAND_W(15)) bus ();
  tetromino_bag #(.RAND_W(15), .RETRY_MAX(15)) dut (.clk(clk), .nreset(nreset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] r;
    logic       rdy;
    logic       v;
    logic [2:0] id;
    logic [2:0] rem;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask
  task automatic drive(input logic [2:0] r, input logic rdy);
    bus.rand_in = {12'h5a5, r};
    bus.piece_ready = rdy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] held;
    logic [7:0] seen;
    logic       dup;
    int         n, cyc;
    tbl[0]  = '{3'd3, 1'b1, 1'b1, 3'd3, 3'd6};
    tbl[1]  = '{3'd3, 1'b1, 1'b0, 3'd3, 3'd6};
    tbl[2]  = '{3'd3, 1'b1, 1'b0, 3'd3, 3'd6};
    tbl[3]  = '{3'd5, 1'b1, 1'b1, 3'd5, 3'd5};
    tbl[4]  = '{3'd0, 1'b0, 1'b1, 3'd5, 3'd5};
    tbl[5]  = '{3'd7, 1'b1, 1'b0, 3'd5, 3'd5};
    tbl[6]  = '{3'd0, 1'b0, 1'b1, 3'd0, 3'd4};
    tbl[7]  = '{3'd2, 1'b1, 1'b0, 3'd0, 3'd4};
    tbl[8]  = '{3'd1, 1'b1, 1'b1, 3'd1, 3'd3};
    tbl[9]  = '{3'd1, 1'b1, 1'b0, 3'd1, 3'd3};
    tbl[10] = '{3'd2, 1'b1, 1'b1, 3'd2, 3'd2};
    tbl[11] = '{3'd2, 1'b1, 1'b0, 3'd2, 3'd2};
    tbl[12] = '{3'd4, 1'b1, 1'b1, 3'd4, 3'd1};
    tbl[13] = '{3'd4, 1'b1, 1'b0, 3'd4, 3'd1};
    tbl[14] = '{3'd6, 1'b1, 1'b1, 3'd6, 3'd7};
    tbl[15] = '{3'd6, 1'b1, 1'b0, 3'd6, 3'd7};
    tbl[16] = '{3'd6, 1'b0, 1'b1, 3'd6, 3'd6};
    drive(3'd7, 1'b0);
    #12;
    chk("reset_valid", 32'(bus.piece_valid), 0);
    chk("reset_id", 32'(bus.piece_id), 0);
    chk("reset_rem", 32'(bus.bag_remaining), 7);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.piece_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_id", i), 32'(bus.piece_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d_rem", i), 32'(bus.bag_remaining), 32'(tbl[i].rem));
      @(negedge clk);
    end
    do_reset();
    drive(3'd7, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("stuck7_retry%0d_valid", i), 32'(bus.piece_valid), 0);
    end
    tick();
    chk("stuck7_fallback_valid", 32'(bus.piece_valid), 1);
    chk("stuck7_fallback_id", 32'(bus.piece_id), 0);
    chk("stuck7_fallback_rem", 32'(bus.bag_remaining), 6);
    do_reset();
    drive(3'd2, 1'b0);
    tick();
    held = bus.piece_id;
    chk("stall_first_id", 32'(held), 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(3'($urandom_range(0, 7)), 1'b0);
      tick();
      chk($sformatf("stall%0d_valid", i), 32'(bus.piece_valid), 1);
      chk($sformatf("stall%0d_id", i), 32'(bus.piece_id), 32'(held));
    end
    @(negedge clk);
    drive(3'd2, 1'b1);
    tick();
    chk("pulse_transfer_valid", 32'(bus.piece_valid), 0);
    @(negedge clk);
    drive(3'd2, 1'b0);
    tick();
    chk("pulse_reject_valid", 32'(bus.piece_valid), 0);
    @(negedge clk);
    drive(3'd3, 1'b0);
    tick();
    chk("pulse_next_id", 32'(bus.piece_id), 3);
    chk("pulse_next_rem", 32'(bus.bag_remaining), 5);
    do_reset();
    drive(3'd4, 1'b0);
    tick();
    chk("hold4_id", 32'(bus.piece_id), 4);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.piece_valid), 0);
    chk("async_rst_rem", 32'(bus.bag_remaining), 7);
    chk("async_rst_id", 32'(bus.piece_id), 0);
    @(negedge clk);
    nreset = 1'b1;
    drive(3'd4, 1'b0);
    tick();
    chk("redraw4_valid", 32'(bus.piece_valid), 1);
    chk("redraw4_id", 32'(bus.piece_id), 4);
    chk("redraw4_rem", 32'(bus.bag_remaining), 6);
    do_reset();
    seen = '0;
    dup = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 7000 && cyc < 90000) begin
      bus.rand_in = 15'($urandom);
      bus.piece_ready = $urandom_range(0, 3) != 0;
      #1;
      if (bus.piece_valid && bus.piece_ready) begin
        if (bus.piece_id == 3'd7) chk("rand_id_not7", 32'(bus.piece_id), 0);
        if (seen[bus.piece_id]) dup = 1'b1;
        seen[bus.piece_id] = 1'b1;
        n++;
        if (n % 7 == 0) begin
          chk($sformatf("bag%0d_perm", n / 7), {23'd0, dup, seen}, 32'h7f);
          seen = '0;
          dup = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("rand_draws_done", 32'(n), 7000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tetromino_bag.md
TETROMINO_BAG -- requirements
Module: tetromino_bag

Interface
REQ-001 The block SHALL provide parameter RAND_W, default 15, giving the width of the random input (the 15-bit LFSR word).
REQ-002 The block SHALL provide parameter RETRY_MAX, default 15, giving the number of rejected draws allowed before the deterministic fallback.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port nreset, input, 1: asynchronous, active-low reset.
REQ-005 Port rand_in, input, RAND_W: free-running pseudo-random word, new value every cycle; only bits [2:0] are used.
REQ-006 Port piece_ready, input, 1: consumer accepts the presented piece.
REQ-007 Port piece_valid, output, 1: piece_id holds a drawn piece.
REQ-008 Port piece_id, output, 3: tetromino index 0..6 (I,O,T,S,Z,J,L); 7 never output.
REQ-009 Port bag_remaining, output, 3: count of pieces not yet drawn from the current bag, 0..7.

Function
REQ-010 The block SHALL implement the 7-bag rule: each consecutive group of 7 loaded pieces is a permutation of 0..6.
REQ-011 The block SHALL hold a 7-bit used mask, a 3-bit piece register, a retry counter of width clog2(RETRY_MAX+1), and a two-state FSM: FILL and HOLD.
REQ-012 In FILL, cand = rand_in[2:0] SHALL be accepted when cand != 7 and mask[cand] == 0.
REQ-013 On acceptance, at the clock edge, piece_id SHALL load cand, mask[cand] SHALL set, and the FSM SHALL go to HOLD.
REQ-014 On rejection with retry counter < RETRY_MAX, the counter SHALL increment and the FSM SHALL stay in FILL.
REQ-015 On rejection with retry counter == RETRY_MAX, piece_id SHALL load the lowest-index piece with a clear mask bit, that bit SHALL set, and the FSM SHALL go to HOLD.
REQ-016 The retry counter SHALL clear on every entry to FILL and on reset.
REQ-017 If a load makes the mask 7'h7F, the mask SHALL instead become 7'h00 in that same edge (new bag); a repeat across the bag boundary is legal.
REQ-018 bag_remaining SHALL equal 7 minus popcount(mask), registered-state derived; after a bag-completing load it SHALL read 7.
REQ-019 piece_valid SHALL be 1 exactly in HOLD; piece_id SHALL be stable while piece_valid is 1.
REQ-020 Transfer occurs on an edge with piece_valid and piece_ready both 1; the FSM SHALL then go to FILL, so piece_valid is 0 for at least one cycle.
REQ-021 piece_ready while piece_valid is 0 SHALL have no effect; piece_valid SHALL not drop without a transfer.
REQ-022 Latency from entering FILL to piece_valid high SHALL be 1 to RETRY_MAX+1 cycles.
REQ-023 rand_in SHALL be sampled only in FILL; its value in HOLD SHALL be ignored.

Reset
REQ-024 Asserting nreset low SHALL immediately clear mask to 0, piece_id to 0, retry counter to 0, piece_valid to 0, set bag_remaining to 7, and set the FSM to FILL.
REQ-025 Reset during HOLD or mid-retry SHALL discard the pending piece; the first draw after release starts a fresh bag.
REQ-026 After nreset deasserts, the first FILL evaluation SHALL occur on the first rising edge.

Verification
REQ-027 Reset, then rand_in[2:0] sequence 3,3,5 with piece_ready=1 -> piece 3 valid one cycle after release; second draw rejects 3 once, then loads 5; bag_remaining reads 6 then 5.
REQ-028 rand_in[2:0] stuck at 7 from reset -> 15 rejected FILL cycles, then piece_id=0 valid after the 16th cycle.
REQ-029 Mask holds {0,1,2,3,4,5} used, rand_in[2:0]=6 -> piece_id=6 loads, mask clears to 0, bag_remaining=7.
REQ-030 piece_ready held 0 for 20 cycles while rand_in changes -> piece_valid stays 1 and piece_id stays constant; one ready pulse gives exactly one transfer.
REQ-031 Pulse nreset low during HOLD with piece 4 -> piece_valid drops asynchronously; post-reset bag_remaining=7 and piece 4 is drawable again.
REQ-032 Random rand_in over 7000 draws with random ready -> every aligned group of 7 is a permutation of 0..6, and 7 is never output.
